// File: rtl/shadow_capture_ms.sv
// Multi-snapshot shadow capture: circular buffer of DEPTH state snapshots, unloaded
// oldest-first over CHAINS_OUT serial chains, plus a registered one-hot error-injection vector.
module shadow_capture_ms #(
  parameter int DFF_BITS   = 1181,
  parameter int CHAINS_OUT = 6,
  parameter int DEPTH      = 4,
  parameter int WRAP       = 0,
  parameter int ERR_W      = 19,
  localparam int ERR_CTRL_W = (ERR_W > 1) ? $clog2(ERR_W) : 1,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  sh_clk,
  input  logic                  sh_rst_n,
  input  logic                  capture_en,
  input  logic [DFF_BITS-1:0]   din,
  input  logic [CHAINS_OUT-1:0] dump_en,
  input  logic                  err_en,
  input  logic [ERR_CTRL_W-1:0] err_ctrl,
  output logic [CHAINS_OUT-1:0] chains_out,
  output logic [CHAINS_OUT-1:0] chains_out_vld,
  output logic [CHAINS_OUT-1:0] chains_out_done,
  output logic [CNT_W-1:0]      snap_cnt,
  output logic                  overflow,
  output logic [ERR_W-1:0]      lcl_err
);

  localparam int L     = (DFF_BITS + CHAINS_OUT - 1) / CHAINS_OUT;
  localparam int PAD   = L * CHAINS_OUT;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IDX_W = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state;
  logic [DFF_BITS-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [IDX_W-1:0]      idx, nxt_idx;
  logic [CHAINS_OUT-1:0] mask, nxt_bits;
  logic [PAD-1:0]        snap_pad;
  logic [L-1:0]          chain_word [CHAINS_OUT];
  logic                  pop, full, cap_store, cap_over;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Output bits are fetched one cycle ahead so every chain output stays registered.
  always_comb begin
    snap_pad = '0;
    snap_pad[DFF_BITS-1:0] = mem[rd_ptr];
    for (int unsigned c = 0; c < CHAINS_OUT; c++)
      chain_word[c] = snap_pad[c*L +: L];
    pop     = (state == SHIFT) && (idx == IDX_W'(L - 1));
    nxt_idx = (state == SHIFT && !pop) ? idx + IDX_W'(1) : '0;
    for (int unsigned c = 0; c < CHAINS_OUT; c++)
      nxt_bits[c] = chain_word[c][nxt_idx];
    full      = (snap_cnt == CNT_W'(DEPTH));
    cap_store = capture_en && (pop || !full);
    cap_over  = capture_en && !pop && full;
  end

  always_ff @(posedge sh_clk) begin
    if (sh_rst_n && (cap_store || (cap_over && WRAP != 0)))
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge sh_clk) begin
    if (!sh_rst_n) begin
      state           <= IDLE;
      idx             <= '0;
      mask            <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      snap_cnt        <= '0;
      overflow        <= 1'b0;
      chains_out      <= '0;
      chains_out_vld  <= '0;
      chains_out_done <= '0;
      lcl_err         <= '0;
    end else begin
      lcl_err <= (err_en && (32'(err_ctrl) < ERR_W)) ? ERR_W'(1) << err_ctrl : '0;

      if (cap_store) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end else if (cap_over) begin
        overflow <= 1'b1;
        if (WRAP != 0) wr_ptr <= ptr_inc(wr_ptr);
      end

      if (pop || (cap_over && WRAP != 0))
        rd_ptr <= ptr_inc(rd_ptr);

      if (cap_store && !pop)
        snap_cnt <= snap_cnt + CNT_W'(1);
      else if (!cap_store && pop)
        snap_cnt <= snap_cnt - CNT_W'(1);

      case (state)
        IDLE: begin
          chains_out_done <= '0;
          if (dump_en != '0 && snap_cnt != '0) begin
            state          <= SHIFT;
            mask           <= dump_en;
            idx            <= '0;
            chains_out     <= nxt_bits & dump_en;
            chains_out_vld <= dump_en;
          end
        end
        SHIFT: begin
          if (pop) begin
            state           <= DONE;
            chains_out      <= '0;
            chains_out_vld  <= '0;
            chains_out_done <= mask;
          end else begin
            idx        <= nxt_idx;
            chains_out <= nxt_bits & mask;
          end
        end
        DONE: begin
          state           <= IDLE;
          chains_out_done <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shadow_capture_ms.sv
// Scoreboard bench for shadow_capture_ms: WRAP=0 and WRAP=1 instances share one stimulus
// stream; each dump's expected snapshot is queued and checked by a negedge monitor.
module tb_shadow_capture_ms;

  localparam int DB = 10;
  localparam int CH = 3;
  localparam int DP = 2;
  localparam int EW = 19;
  localparam int L  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          capture_en = 1'b0;
  logic [DB-1:0] din = '0;
  logic [CH-1:0] dump_en = '0;
  logic          err_en = 1'b0;
  logic [4:0]    err_ctrl = '0;

  logic [CH-1:0] co [2];
  logic [CH-1:0] cv [2];
  logic [CH-1:0] cd [2];
  logic [1:0]    cnt [2];
  logic          ovf [2];
  logic [EW-1:0] lerr [2];

  typedef struct packed {
    logic [CH-1:0] mask;
    logic [11:0]   data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          total = 0;
  int          bad = 0;
  int          pos [2];
  logic [11:0] word [2];
  bit          rst_at_edge = 1'b0;

  shadow_capture_ms #(.DFF_BITS(DB), .CHAINS_OUT(CH), .DEPTH(DP), .WRAP(0), .ERR_W(EW)) u_nowrap (
    .sh_clk(clk), .sh_rst_n(rst_n), .capture_en(capture_en), .din(din), .dump_en(dump_en),
    .err_en(err_en), .err_ctrl(err_ctrl), .chains_out(co[0]), .chains_out_vld(cv[0]),
    .chains_out_done(cd[0]), .snap_cnt(cnt[0]), .overflow(ovf[0]), .lcl_err(lerr[0])
  );

  shadow_capture_ms #(.DFF_BITS(DB), .CHAINS_OUT(CH), .DEPTH(DP), .WRAP(1), .ERR_W(EW)) u_wrap (
    .sh_clk(clk), .sh_rst_n(rst_n), .capture_en(capture_en), .din(din), .dump_en(dump_en),
    .err_en(err_en), .err_ctrl(err_ctrl), .chains_out(co[1]), .chains_out_vld(cv[1]),
    .chains_out_done(cd[1]), .snap_cnt(cnt[1]), .overflow(ovf[1]), .lcl_err(lerr[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_at_edge = !rst_n;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic fail(input string nm, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s actual=%0h required=no activity", nm, act);
  endtask

  task automatic drop_front(input int d);
    if (d == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic mon(input int d);
    exp_t f;
    bit   have;
    have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
    f = '0;
    if (have) f = (d == 0) ? q0[0] : q1[0];
    if (rst_at_edge) begin
      check($sformatf("rst_outputs%0d", d), {23'd0, co[d], cv[d], cd[d]}, 0);
      if (pos[d] > 0 && have) drop_front(d);
      pos[d]  = 0;
      word[d] = '0;
    end else if (cv[d] != '0) begin
      if (!have) fail($sformatf("unexpected_vld%0d", d), cv[d]);
      else       check($sformatf("vld_mask%0d", d), cv[d], f.mask);
      check($sformatf("done_during_shift%0d", d), cd[d], 0);
      check($sformatf("unmasked_data%0d", d), co[d] & ~cv[d], 0);
      if (pos[d] < L)
        for (int c = 0; c < CH; c++)
          if (cv[d][c]) word[d] |= 12'(co[d][c]) << (c*L + pos[d]);
      pos[d]++;
    end else if (cd[d] != '0) begin
      check($sformatf("done_data%0d", d), co[d], 0);
      if (!have) begin
        fail($sformatf("unexpected_done%0d", d), cd[d]);
      end else begin
        drop_front(d);
        check($sformatf("done_mask%0d", d), cd[d], f.mask);
        check($sformatf("shift_len%0d", d), pos[d], L);
        check($sformatf("snapshot%0d", d), word[d], f.data);
      end
      pos[d]  = 0;
      word[d] = '0;
    end else if (co[d] != '0) begin
      fail($sformatf("idle_data%0d", d), co[d]);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [DB-1:0] v);
    capture_en = 1'b1;
    din = v;
    tick(1);
    capture_en = 1'b0;
  endtask

  task automatic push(input int d, input logic [CH-1:0] m, input logic [DB-1:0] v);
    exp_t e;
    logic [11:0] mx;
    mx = {{4{m[2]}}, {4{m[1]}}, {4{m[0]}}};
    e.mask = m;
    e.data = {2'b00, v} & mx;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic check_cnt(input string nm, input logic [1:0] ca, input logic [1:0] cb);
    check({nm, "_nowrap"}, cnt[0], ca);
    check({nm, "_wrap"}, cnt[1], cb);
  endtask

  task automatic check_ovf(input string nm, input logic oa, input logic ob);
    check({nm, "_nowrap"}, ovf[0], oa);
    check({nm, "_wrap"}, ovf[1], ob);
  endtask

  // Full dump; optionally captures in the last SHIFT cycle. Returns in the next IDLE cycle.
  task automatic dump(input logic [CH-1:0] m, input logic [DB-1:0] va, input logic [DB-1:0] vb,
                      input logic [1:0] ca, input logic [1:0] cb,
                      input bit cap, input logic [DB-1:0] cval);
    push(0, m, va);
    push(1, m, vb);
    dump_en = m;
    tick(1);
    dump_en = '0;
    tick(L - 1);
    if (cap) begin
      capture_en = 1'b1;
      din = cval;
    end
    tick(1);
    capture_en = 1'b0;
    check_cnt("cnt_in_done", ca, cb);
    tick(1);
  endtask

  typedef struct {
    logic          en;
    logic [4:0]    ctrl;
    logic [EW-1:0] exp;
  } err_vec_t;

  err_vec_t evec [6] = '{
    '{1'b1, 5'd5,  19'h00020},
    '{1'b1, 5'd18, 19'h40000},
    '{1'b1, 5'd19, 19'h00000},
    '{1'b1, 5'd20, 19'h00000},
    '{1'b0, 5'd5,  19'h00000},
    '{1'b1, 5'd0,  19'h00001}
  };

  initial begin
    pos[0] = 0; pos[1] = 0;
    word[0] = '0; word[1] = '0;
    tick(3);
    rst_n = 1'b1;
    check_cnt("reset_cnt", 2'd0, 2'd0);
    check_ovf("reset_ovf", 1'b0, 1'b0);
    check("reset_lerr_nowrap", lerr[0], 0);
    check("reset_lerr_wrap", lerr[1], 0);

    capture(10'h2B5);
    check_cnt("cnt_after_cap", 2'd1, 2'd1);
    dump(3'b111, 10'h2B5, 10'h2B5, 2'd0, 2'd0, 1'b0, '0);

    capture(10'h0AA);
    capture(10'h0BB);
    check_cnt("cnt_full", 2'd2, 2'd2);
    check_ovf("ovf_full_no_drop", 1'b0, 1'b0);
    dump(3'b111, 10'h0AA, 10'h0AA, 2'd2, 2'd2, 1'b1, 10'h155);
    check_ovf("ovf_pop_capture", 1'b0, 1'b0);
    dump(3'b111, 10'h0BB, 10'h0BB, 2'd1, 2'd1, 1'b0, '0);
    dump(3'b111, 10'h155, 10'h155, 2'd0, 2'd0, 1'b0, '0);

    capture(10'h001);
    capture(10'h002);
    capture(10'h003);
    check_cnt("cnt_over", 2'd2, 2'd2);
    check_ovf("ovf_over", 1'b1, 1'b1);
    dump(3'b111, 10'h001, 10'h002, 2'd1, 2'd1, 1'b0, '0);
    dump(3'b111, 10'h002, 10'h003, 2'd0, 2'd0, 1'b0, '0);

    dump_en = 3'b010;
    tick(3);
    dump_en = '0;
    tick(4);
    check_cnt("cnt_empty_dump", 2'd0, 2'd0);

    capture(10'h3C6);
    dump(3'b010, 10'h3C6, 10'h3C6, 2'd0, 2'd0, 1'b0, '0);

    capture(10'h1E7);
    push(0, 3'b010, 10'h1E7);
    push(1, 3'b010, 10'h1E7);
    dump_en = 3'b010;
    tick(1);
    dump_en = '0;
    tick(2);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    check_cnt("cnt_after_abort", 2'd0, 2'd0);
    check_ovf("ovf_after_reset", 1'b0, 1'b0);
    tick(8);

    for (int i = 0; i < 6; i++) begin
      err_en = evec[i].en;
      err_ctrl = evec[i].ctrl;
      tick(1);
      check($sformatf("lcl_err_nowrap_%0d", i), lerr[0], evec[i].exp);
      check($sformatf("lcl_err_wrap_%0d", i), lerr[1], evec[i].exp);
    end
    err_en = 1'b0;
    tick(2);
    check("pending_nowrap", q0.size(), 0);
    check("pending_wrap", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
